// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if
// Bundles the requester and read-port signals of reg_bank_arbiter.
//   req       [2:0]         write request per requester (level, held until granted)
//   req_addr  [5:0]         bank address, requester i uses [2i+1:2i]
//   req_data  [3*WIDTH-1:0] write data, requester i uses [WIDTH*i +: WIDTH]
//   grant     [2:0]         registered one-hot grant pulse
//   rd_addr   [1:0]         read address into the bank
//   rd_data   [WIDTH-1:0]   registered read data (write-through)
//   conflict                registered pulse, 2+ eligible requesters at last edge
//   wr_count  [7:0]         saturating count of committed writes
// master: requester/reader side; slave: the arbiter.
interface reg_bank_arbiter_if #(
   parameter int WIDTH = 7
);
   logic [2:0]         req;
   logic [5:0]         req_addr;
   logic [3*WIDTH-1:0] req_data;
   logic [2:0]         grant;
   logic [1:0]         rd_addr;
   logic [WIDTH-1:0]   rd_data;
   logic               conflict;
   logic [7:0]         wr_count;

   modport master (
      output req, req_addr, req_data, rd_addr,
      input  grant, rd_data, conflict, wr_count
   );

   modport slave (
      input  req, req_addr, req_data, rd_addr,
      output grant, rd_data, conflict, wr_count
   );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Four-entry register bank written by three requesters through a round-robin
// arbiter. One write per edge at most; the winner gets a one-cycle grant.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    reg_bank_arbiter_if.slave (requests, grant, read port, status)
module reg_bank_arbiter #(
   parameter int WIDTH = 7
) (
   input  logic              clk,
   input  logic              reset,
   reg_bank_arbiter_if.slave bus
);

   logic [WIDTH-1:0] bank [4];
   logic [1:0]       rr_ptr;

   logic [2:0]       eligible_p0;
   logic             vld_p0;
   logic [1:0]       win_idx_p0;
   logic [1:0]       win_addr_p0;
   logic [WIDTH-1:0] win_data_p0;
   logic [2:0]       grant_p0;
   logic             conflict_p0;
   logic [1:0]       rr_next_p0;
   logic [WIDTH-1:0] rd_data_p0;

   // (a + b) mod 3 for operands already in 0..2
   function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= 3'd3)
         sum = sum - 3'd3;
      return sum[1:0];
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   endfunction

   // Stage p0: arbitration, write select and read bypass
   always_comb begin
      // A requester granted this cycle is masked so its held request
      // is not written a second time at the next edge.
      eligible_p0 = bus.req & ~bus.grant;
      vld_p0      = 1'b0;
      win_idx_p0  = 2'd0;
      // Scan from the farthest offset down so the nearest one to rr_ptr wins.
      for (int k = 2; k >= 0; k--) begin
         if (eligible_p0[mod3_add(rr_ptr, 2'(k))]) begin
            vld_p0     = 1'b1;
            win_idx_p0 = mod3_add(rr_ptr, 2'(k));
         end
      end

      win_addr_p0 = bus.req_addr[1:0];
      win_data_p0 = bus.req_data[WIDTH-1:0];
      case (win_idx_p0)
         2'd1: begin
            win_addr_p0 = bus.req_addr[3:2];
            win_data_p0 = bus.req_data[2*WIDTH-1:WIDTH];
         end
         2'd2: begin
            win_addr_p0 = bus.req_addr[5:4];
            win_data_p0 = bus.req_data[3*WIDTH-1:2*WIDTH];
         end
         default: ;
      endcase

      grant_p0    = vld_p0 ? (3'b001 << win_idx_p0) : 3'b000;
      conflict_p0 = (eligible_p0[0] & eligible_p0[1]) |
                    (eligible_p0[0] & eligible_p0[2]) |
                    (eligible_p0[1] & eligible_p0[2]);
      rr_next_p0  = vld_p0 ? mod3_add(win_idx_p0, 2'd1) : rr_ptr;

      // Write-through: a read of the address being written returns the new data.
      if (vld_p0 && (win_addr_p0 == bus.rd_addr))
         rd_data_p0 = win_data_p0;
      else
         rd_data_p0 = bank[bus.rd_addr];
   end

   // Stage p1: registered bank, outputs and pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++)
            bank[i] <= '0;
         bus.grant    <= 3'b000;
         bus.rd_data  <= '0;
         bus.conflict <= 1'b0;
         bus.wr_count <= 8'd0;
         rr_ptr       <= 2'd0;
      end else begin
         if (vld_p0) begin
            bank[win_addr_p0] <= win_data_p0;
            bus.wr_count      <= sat_inc(bus.wr_count);
         end
         bus.grant    <= grant_p0;
         bus.rd_data  <= rd_data_p0;
         bus.conflict <= conflict_p0;
         rr_ptr       <= rr_next_p0;
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Directed bench for reg_bank_arbiter: reset hold, round-robin rotation,
// single requester, masking of a held request, write-through read,
// reset override and write-counter saturation.
module tb_reg_bank_arbiter;
   localparam int WIDTH = 7;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   reg_bank_arbiter_if #(.WIDTH(WIDTH)) bus ();

   reg_bank_arbiter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] a, input logic [WIDTH-1:0] d);
      bus.req_addr[2*i +: 2]         = a;
      bus.req_data[WIDTH*i +: WIDTH] = d;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      bus.req = 3'b000;
      tick();
      tick();
      reset = 1'b1;
   endtask

   logic [2:0] rot [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      reset        = 1'b0;
      bus.req      = 3'b000;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.rd_addr  = 2'd0;

      // Reset held with all three requesting
      set_req(0, 2'd0, 7'h11);
      set_req(1, 2'd1, 7'h22);
      set_req(2, 2'd3, 7'h33);
      bus.req = 3'b111;
      for (int n = 0; n < 3; n++) begin
         tick();
         check($sformatf("rst_grant%0d", n), bus.grant, 3'b000);
         check($sformatf("rst_wrcnt%0d", n), bus.wr_count, 8'd0);
         check($sformatf("rst_rd%0d", n), bus.rd_data, 7'h00);
         check($sformatf("rst_conf%0d", n), bus.conflict, 1'b0);
      end

      // Release: grants 001, 010, 100 with requesters dropping on grant
      reset = 1'b1;
      tick();
      check("rr_g0", bus.grant, 3'b001);
      check("rr_c0", bus.conflict, 1'b1);
      check("rr_w0", bus.wr_count, 8'd1);
      check("rr_byp0", bus.rd_data, 7'h11);
      bus.req[0] = 1'b0;
      tick();
      check("rr_g1", bus.grant, 3'b010);
      check("rr_c1", bus.conflict, 1'b1);
      check("rr_w1", bus.wr_count, 8'd2);
      bus.req[1] = 1'b0;
      tick();
      check("rr_g2", bus.grant, 3'b100);
      check("rr_c2", bus.conflict, 1'b0);
      check("rr_w2", bus.wr_count, 8'd3);
      bus.req = 3'b000;
      bus.rd_addr = 2'd1;
      tick();
      check("rr_idle_g", bus.grant, 3'b000);
      check("bank1", bus.rd_data, 7'h22);
      bus.rd_addr = 2'd3;
      tick();
      check("bank3", bus.rd_data, 7'h33);
      bus.rd_addr = 2'd2;
      tick();
      check("bank2", bus.rd_data, 7'h00);
      bus.rd_addr = 2'd0;
      tick();
      check("bank0", bus.rd_data, 7'h11);

      // All three held continuously: grants keep rotating
      do_reset();
      bus.req = 3'b111;
      for (int n = 0; n < 6; n++) begin
         tick();
         check($sformatf("rot_g%0d", n), bus.grant, rot[n]);
         check($sformatf("rot_c%0d", n), bus.conflict, 1'b1);
      end
      bus.req = 3'b000;
      tick();

      // Single requester 1 writes addr 2
      do_reset();
      set_req(1, 2'd2, 7'b0000111);
      bus.rd_addr = 2'd0;
      bus.req = 3'b010;
      tick();
      check("single_g", bus.grant, 3'b010);
      check("single_w", bus.wr_count, 8'd1);
      bus.req = 3'b000;
      bus.rd_addr = 2'd2;
      tick();
      check("single_g_off", bus.grant, 3'b000);
      check("single_rd", bus.rd_data, 7'b0000111);
      check("single_w_hold", bus.wr_count, 8'd1);

      // Requester 0 held alone: grant every other cycle
      do_reset();
      set_req(0, 2'd1, 7'h05);
      bus.req = 3'b001;
      for (int n = 0; n < 6; n++) begin
         tick();
         check($sformatf("mask_g%0d", n), bus.grant, (n % 2 == 0) ? 3'b001 : 3'b000);
         check($sformatf("mask_w%0d", n), bus.wr_count, 8'(n / 2 + 1));
      end
      bus.req = 3'b000;
      tick();

      // Write-through: read addr 1 while requester 2 writes it
      do_reset();
      bus.rd_addr = 2'd1;
      set_req(2, 2'd1, 7'h55);
      bus.req = 3'b100;
      tick();
      check("wt_g", bus.grant, 3'b100);
      check("wt_rd", bus.rd_data, 7'h55);
      bus.req = 3'b000;

      // Reset overrides a pending request
      set_req(1, 2'd0, 7'h12);
      set_req(2, 2'd0, 7'h34);
      bus.req = 3'b110;
      reset = 1'b0;
      tick();
      check("ovr_g", bus.grant, 3'b000);
      check("ovr_w", bus.wr_count, 8'd0);
      reset = 1'b1;
      bus.req = 3'b000;
      bus.rd_addr = 2'd0;
      tick();
      check("ovr_g2", bus.grant, 3'b000);
      check("ovr_bank0", bus.rd_data, 7'h00);

      // Two alternating requesters force a write every edge
      set_req(0, 2'd2, 7'h01);
      set_req(1, 2'd2, 7'h02);
      bus.req = 3'b011;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (n == 254) check("sat_254", bus.wr_count, 8'd254);
         if (n == 255) check("sat_255", bus.wr_count, 8'd255);
         if (n == 300) begin
            check("sat_300", bus.wr_count, 8'd255);
            check("sat_conf", bus.conflict, 1'b0);
         end
      end
      bus.req = 3'b000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 7, data width of each bank register.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-004 SHALL have port: req  input  3  write request per requester i (bit i); level, held until granted.
REQ-005 SHALL have port: req_addr  input  6  bank address per requester; requester i uses bits [2i+1:2i].
REQ-006 SHALL have port: req_data  input  3*WIDTH  write data per requester; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-007 SHALL have port: grant  output  3  registered one-hot grant pulse; all-zero when no grant.
REQ-008 SHALL have port: rd_addr  input  2  read address into the bank.
REQ-009 SHALL have port: rd_data  output  WIDTH  registered read data.
REQ-010 SHALL have port: conflict  output  1  registered pulse; more than one eligible requester at the last edge.
REQ-011 SHALL have port: wr_count  output  8  saturating count of committed writes.

Function
REQ-012 SHALL contain a bank of 4 registers of WIDTH bits, written only through arbitration.
REQ-013 Eligible set at an edge SHALL be req AND NOT grant (a requester granted in the current cycle is masked at the next edge; no double write).
REQ-014 Arbitration SHALL be round-robin over the eligible set, searching from rr_ptr upward modulo 3 (order rr_ptr, rr_ptr+1, rr_ptr+2).
REQ-015 At an edge with winner w: bank[req_addr of w] <= req_data of w; grant <= one-hot(w); rr_ptr <= (w+1) mod 3.
REQ-016 At an edge with empty eligible set: no write, grant <= 000, rr_ptr unchanged.
REQ-017 Write latency SHALL be one edge: data visible in the bank, and grant high, during the cycle following the sampling edge.
REQ-018 grant SHALL be high for exactly one cycle per accepted request.
REQ-019 A requester SHALL keep req, req_addr and req_data stable until its grant is seen; the block samples them only at the winning edge.
REQ-020 Non-winning requesters SHALL lose nothing; they remain eligible at later edges.
REQ-021 With all three requesting continuously, grants SHALL rotate; no requester waits more than 3 edges after becoming eligible.
REQ-022 conflict <= 1 when the eligible set has 2 or more bits set, else 0.
REQ-023 rd_data <= bank[rd_addr] every edge; if the same edge writes rd_addr, rd_data SHALL take the new write data (write-through bypass).
REQ-024 wr_count SHALL increment by 1 per committed write and saturate at 255 (no wrap).
REQ-025 req_addr values of several requesters MAY be equal; only the winner's write occurs at an edge.

Reset
REQ-026 At any edge with reset=0: bank all 0, grant=000, rd_data=0, conflict=0, wr_count=0, rr_ptr=0.
REQ-027 reset=0 SHALL override any pending request at that edge: no write, no grant, pending requests need not be remembered.
REQ-028 First edge after reset deasserts SHALL arbitrate normally, starting priority at requester 0.

Verification
REQ-029 Reset hold, req=111 -> grant=000, wr_count=0, rd_data=0 throughout; after release first grant=001.
REQ-030 Single requester: req=010, addr1=2, data1=7'b0000111, then drop req on grant -> grant=010 for one cycle, next rd_addr=2 read gives 7'b0000111, wr_count=1.
REQ-031 All three held, distinct addrs 0/1/3, data 0x11/0x22/0x33 -> grants 001,010,100 on consecutive cycles, conflict=1 on first two edges, bank[0]=0x11, bank[1]=0x22, bank[3]=0x33.
REQ-032 Requester 0 holds req continuously alone -> grant 001 every other cycle only (masking rule), wr_count increments every 2 cycles.
REQ-033 rd_addr=1 while requester 2 writes addr 1 with 0x55 -> rd_data=0x55 in the same cycle grant=100 is high.
REQ-034 reset=0 asserted while req=110 pending -> no grant that edge, bank stays 0; 300 forced writes -> wr_count stops at 255.
